// File: rtl/bin2bcd_seq_pkg.sv
// ============================================================================
// Module : bin2bcd_seq_pkg
// Brief  : Shared encodings and BCD constants for the binary-to-BCD converter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bin2bcd_seq_pkg;

    localparam int c_digit_w = 4;

    // Largest legal BCD digit, common with the downstream BCD adder
    localparam logic [c_digit_w-1:0] c_bcd_max = 4'd9;
    localparam logic [c_digit_w-1:0] c_adj_min = 4'd5;
    localparam logic [c_digit_w-1:0] c_adj_add = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq_digit_adj.sv
// ============================================================================
// Module : bin2bcd_seq_digit_adj
// Brief  : Double-dabble digit correction: adds 3 (mod 16) to digits of 5 or more.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq_digit_adj
    import bin2bcd_seq_pkg::*;
(
    input  logic [c_digit_w-1:0] d,
    output logic [c_digit_w-1:0] q
);

    assign q = (d >= c_adj_min) ? (d + c_adj_add) : d;

endmodule

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
// Module : bin2bcd_seq
// Brief  : Sequential shift-and-add-3 binary-to-BCD converter, valid/ready I/O.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BIN_W-1:0]              bin_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [c_digit_w*DIGITS-1:0]   bcd_out,
    output logic                          overflow
);

    localparam int c_bcd_w = c_digit_w * DIGITS;
    localparam int c_cnt_w = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(BIN_W - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [BIN_W-1:0]     r_bin;
    logic [c_bcd_w-1:0]   r_bcd;
    logic                 r_ovf;
    logic [c_bcd_w-1:0]   w_adj;
    logic                 w_in_ready;
    logic                 w_out_valid;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            bin2bcd_seq_digit_adj u_adj (
                .d (r_bcd[gi*c_digit_w +: c_digit_w]),
                .q (w_adj[gi*c_digit_w +: c_digit_w])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == c_cnt_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Adjust happens on current digits, then {bcd, bin} shifts left one bit;
    // whatever falls out of the top digit marks the result as unrepresentable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_ovf <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == ST_IDLE && in_valid) begin
            r_bin <= bin_in;
            r_bcd <= '0;
            r_ovf <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == ST_SHIFT) begin
            r_bcd <= {w_adj[c_bcd_w-2:0], r_bin[BIN_W-1]};
            r_bin <= {r_bin[BIN_W-2:0], 1'b0};
            r_ovf <= r_ovf | w_adj[c_bcd_w-1];
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign bcd_out   = r_bcd;
    assign overflow  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
// ============================================================================
// Module : tb_bin2bcd_seq
// Brief  : Self-checking bench for bin2bcd_seq (3-digit and 2-digit instances).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  bin_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] bcd_out;
    logic        overflow;

    logic        in_valid2 = 1'b0;
    logic        in_ready2;
    logic [7:0]  bin_in2 = '0;
    logic        out_valid2;
    logic        out_ready2 = 1'b0;
    logic [7:0]  bcd_out2;
    logic        overflow2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
        .clk (clk), .rst (rst),
        .in_valid (in_valid), .in_ready (in_ready), .bin_in (bin_in),
        .out_valid (out_valid), .out_ready (out_ready),
        .bcd_out (bcd_out), .overflow (overflow)
    );

    bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
        .clk (clk), .rst (rst),
        .in_valid (in_valid2), .in_ready (in_ready2), .bin_in (bin_in2),
        .out_valid (out_valid2), .out_ready (out_ready2),
        .bcd_out (bcd_out2), .overflow (overflow2)
    );

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] bcd;
        int          stall;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] model_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges from the accept until out_valid, with an upper bound
    task automatic wait_result(output int lat, output bit rdy_seen);
        lat = 0;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 20) begin
            if (in_ready) rdy_seen = 1'b1;
            tick();
            lat++;
        end
    endtask

    task automatic convert(input logic [7:0] b, input int stall,
                           input logic [11:0] exp_bcd, input string tag);
        int lat;
        bit rdy_seen;
        logic [11:0] held;
        in_valid = 1'b1;
        bin_in   = b;
        tick();
        in_valid = 1'b0;
        bin_in   = 8'($urandom);
        wait_result(lat, rdy_seen);
        chk({tag, " latency"}, lat, 8);
        chk({tag, " in_ready during conversion"}, {31'd0, rdy_seen}, 0);
        held = bcd_out;
        for (int i = 0; i < stall; i++) tick();
        chk({tag, " held stable"}, {20'd0, bcd_out}, {20'd0, held});
        chk({tag, " bcd_out"}, {20'd0, bcd_out}, {20'd0, exp_bcd});
        chk({tag, " overflow"}, {31'd0, overflow}, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, " back to idle"}, {30'd0, in_ready, out_valid}, 32'b10);
    endtask

    task automatic convert2(input logic [7:0] b, input logic [7:0] exp_bcd,
                            input logic exp_ovf, input string tag);
        int lat;
        in_valid2 = 1'b1;
        bin_in2   = b;
        tick();
        in_valid2 = 1'b0;
        lat = 0;
        while (!out_valid2 && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, " latency"}, lat, 8);
        chk({tag, " overflow"}, {31'd0, overflow2}, {31'd0, exp_ovf});
        if (!exp_ovf) chk({tag, " bcd_out"}, {24'd0, bcd_out2}, {24'd0, exp_bcd});
        out_ready2 = 1'b1;
        tick();
        out_ready2 = 1'b0;
    endtask

    initial begin
        vec_t vecs[10];
        int lat;
        bit rdy_seen;
        vecs[0] = '{8'd0,   12'h000, 0};
        vecs[1] = '{8'd255, 12'h255, 0};
        vecs[2] = '{8'd1,   12'h001, 2};
        vecs[3] = '{8'd9,   12'h009, 0};
        vecs[4] = '{8'd10,  12'h010, 1};
        vecs[5] = '{8'd99,  12'h099, 3};
        vecs[6] = '{8'd100, 12'h100, 0};
        vecs[7] = '{8'd128, 12'h128, 4};
        vecs[8] = '{8'd199, 12'h199, 0};
        vecs[9] = '{8'd250, 12'h250, 1};

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset state", {16'd0, in_ready, out_valid, overflow, 1'b0, bcd_out}, {16'd0, 4'b1000, 12'h000});

        for (int i = 0; i < 10; i++) begin
            convert(vecs[i].bin, vecs[i].stall, vecs[i].bcd, $sformatf("vec%0d", i));
        end

        // Second request held during a stalled result must wait for IDLE
        in_valid = 1'b1;
        bin_in   = 8'd12;
        tick();
        bin_in = 8'd99;
        wait_result(lat, rdy_seen);
        chk("seq12 latency", lat, 8);
        for (int i = 0; i < 5; i++) begin
            chk("seq12 stall value", {20'd0, bcd_out}, 32'h012);
            chk("seq12 stall in_ready", {30'd0, in_ready, out_valid}, 32'b01);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("seq12 release", {30'd0, in_ready, out_valid}, 32'b10);
        tick();
        in_valid = 1'b0;
        wait_result(lat, rdy_seen);
        chk("seq99 latency", lat, 8);
        chk("seq99 bcd_out", {20'd0, bcd_out}, 32'h099);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset during the fourth SHIFT cycle discards the conversion
        in_valid = 1'b1;
        bin_in   = 8'd200;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid reset", {16'd0, in_ready, out_valid, overflow, 1'b0, bcd_out}, {16'd0, 4'b1000, 12'h000});
        for (int i = 0; i < 10; i++) begin
            if (out_valid) chk("mid reset spurious out_valid", {31'd0, out_valid}, 0);
            tick();
        end
        convert(8'd7, 0, 12'h007, "after reset");

        convert2(8'd200, 8'h00, 1'b1, "two-digit 200");
        convert2(8'd99, 8'h99, 1'b0, "two-digit 99");
        convert2(8'd100, 8'h00, 1'b1, "two-digit 100");

        for (int n = 0; n < 500; n++) begin
            int v;
            int st;
            v = int'($urandom_range(255, 0));
            st = int'($urandom_range(3, 0));
            in_valid = 1'b1;
            bin_in   = 8'(v);
            tick();
            in_valid = 1'b0;
            wait_result(lat, rdy_seen);
            for (int i = 0; i < st; i++) tick();
            chk($sformatf("rand %0d value", v), {19'd0, overflow, bcd_out}, {19'd0, 1'b0, model_bcd(v)});
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
